// File: rtl/ldi_serializer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ldi_serializer : 7:1 LVDS display-interface serializer with idle insertion |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module ldi_serializer #(
   parameter int                 LANES     = 4,
   parameter logic [7*LANES-1:0] IDLE_WORD = '0
) (
   input  logic                 clock,
   input  logic                 reset_n,
   input  logic [7*LANES-1:0]   in_data,
   input  logic                 in_valid,
   output logic                 in_ready,
   output logic [LANES-1:0]     serial_data,
   output logic                 serial_clock,
   output logic                 frame_slot0,
   output logic                 underflow,
   output logic [15:0]          underflow_count,
   input  logic                 underflow_clear
);

   localparam int         W           = 7 * LANES;
   localparam logic [2:0] SLOT_LAST   = 3'd6;
   localparam logic [6:0] CLK_PATTERN = 7'b1100011;

   logic [2:0]       slot_q, slot_d;
   logic [W-1:0]     shift_q, shift_d;
   logic [W-1:0]     hold_data_q, hold_data_d;
   logic             hold_full_q, hold_full_d;
   logic [LANES-1:0] serial_data_q, serial_data_d;
   logic             serial_clock_q, serial_clock_d;
   logic             frame_slot0_q, frame_slot0_d;
   logic             underflow_q, underflow_d;
   logic [15:0]      underflow_count_q, underflow_count_d;
   logic             accept;
   logic             load;

   always_comb begin
      accept            = in_valid && !hold_full_q;
      load              = (slot_q == SLOT_LAST);
      slot_d            = load ? 3'd0 : slot_q + 3'd1;
      shift_d           = shift_q;
      hold_data_d       = hold_data_q;
      hold_full_d       = hold_full_q;
      underflow_d       = underflow_q;
      underflow_count_d = underflow_count_q;

      if (load) begin
         if (hold_full_q) begin
            shift_d     = hold_data_q;
            hold_full_d = 1'b0;
         end else if (accept) begin
            // Word arriving exactly on the load edge bypasses the holding register.
            shift_d = in_data;
         end else begin
            shift_d     = IDLE_WORD;
            underflow_d = 1'b1;
            if (underflow_count_q != 16'hFFFF) begin
               underflow_count_d = underflow_count_q + 16'd1;
            end
         end
      end else begin
         for (int k = 0; k < LANES; k++) begin
            shift_d[7*k +: 7] = {shift_q[7*k +: 6], 1'b0};
         end
         if (accept) begin
            hold_data_d = in_data;
            hold_full_d = 1'b1;
         end
      end

      if (underflow_clear) begin
         underflow_d       = 1'b0;
         underflow_count_d = 16'd0;
      end

      // Outputs are registered copies of what the next slot must drive.
      serial_clock_d = CLK_PATTERN[3'd6 - slot_d];
      frame_slot0_d  = (slot_d == 3'd0);
      for (int k = 0; k < LANES; k++) begin
         serial_data_d[k] = shift_d[7*k+6];
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         slot_q            <= SLOT_LAST;
         shift_q           <= IDLE_WORD;
         hold_data_q       <= '0;
         hold_full_q       <= 1'b0;
         serial_data_q     <= '0;
         serial_clock_q    <= 1'b0;
         frame_slot0_q     <= 1'b0;
         underflow_q       <= 1'b0;
         underflow_count_q <= 16'd0;
      end else begin
         slot_q            <= slot_d;
         shift_q           <= shift_d;
         hold_data_q       <= hold_data_d;
         hold_full_q       <= hold_full_d;
         serial_data_q     <= serial_data_d;
         serial_clock_q    <= serial_clock_d;
         frame_slot0_q     <= frame_slot0_d;
         underflow_q       <= underflow_d;
         underflow_count_q <= underflow_count_d;
      end
   end

   assign in_ready        = !hold_full_q;
   assign serial_data     = serial_data_q;
   assign serial_clock    = serial_clock_q;
   assign frame_slot0     = frame_slot0_q;
   assign underflow       = underflow_q;
   assign underflow_count = underflow_count_q;

endmodule
`default_nettype wire

// File: tb/tb_ldi_serializer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_ldi_serializer : directed bench with a word-level reference model       |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_ldi_serializer;

   localparam int         LANES = 4;
   localparam int         W     = 7 * LANES;
   localparam logic [W-1:0] IDLE = '0;

   logic             clock;
   logic             reset_n;
   logic [W-1:0]     in_data;
   logic             in_valid;
   logic             in_ready;
   logic [LANES-1:0] serial_data;
   logic             serial_clock;
   logic             frame_slot0;
   logic             underflow;
   logic [15:0]      underflow_count;
   logic             underflow_clear;

   ldi_serializer #(.LANES(LANES), .IDLE_WORD(IDLE)) dut (
      .clock           (clock),
      .reset_n         (reset_n),
      .in_data         (in_data),
      .in_valid        (in_valid),
      .in_ready        (in_ready),
      .serial_data     (serial_data),
      .serial_clock    (serial_clock),
      .frame_slot0     (frame_slot0),
      .underflow       (underflow),
      .underflow_count (underflow_count),
      .underflow_clear (underflow_clear)
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Word-level model: edge n after reset release is a load when n is a multiple of 7.
   int           m_edge   = 0;
   int           m_slot   = 0;
   bit           m_active = 0;
   bit           m_full   = 0;
   bit           m_uf     = 0;
   bit           m_acc;
   logic [15:0]  m_cnt    = 16'd0;
   logic [W-1:0] m_cur    = IDLE;
   logic [W-1:0] m_hold   = '0;
   logic [W-1:0] tx_log[$];

   initial forever begin
      @(posedge clock or negedge reset_n);
      if (!reset_n) begin
         m_edge = 0; m_slot = 0; m_active = 0; m_full = 0;
         m_uf = 0; m_cnt = 16'd0; m_cur = IDLE;
         tx_log.delete();
      end else begin
         m_acc = in_valid && !m_full;
         if (m_edge % 7 == 0) begin
            if (m_full) begin
               m_cur  = m_hold;
               m_full = 0;
            end else if (m_acc) begin
               m_cur = in_data;
            end else begin
               m_cur = IDLE;
               m_uf  = 1;
               if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            end
            tx_log.push_back(m_cur);
         end else if (m_acc) begin
            m_hold = in_data;
            m_full = 1;
         end
         if (underflow_clear) begin
            m_uf  = 0;
            m_cnt = 16'd0;
         end
         m_slot   = m_edge % 7;
         m_active = 1;
         m_edge++;
      end
   end

   logic [6:0]       c_pat = 7'b1100011;
   logic [LANES-1:0] e_sd;
   logic             e_sc;

   initial forever begin
      @(negedge clock);
      for (int k = 0; k < LANES; k++) e_sd[k] = m_active ? m_cur[7*k+6-m_slot] : 1'b0;
      e_sc = m_active ? c_pat[6-m_slot] : 1'b0;
      chk("serial_data",     32'(serial_data),     32'(e_sd));
      chk("serial_clock",    32'(serial_clock),    32'(e_sc));
      chk("frame_slot0",     32'(frame_slot0),     32'(m_active && m_slot == 0));
      chk("in_ready",        32'(in_ready),        32'(!m_full));
      chk("underflow",       32'(underflow),       32'(m_uf));
      chk("underflow_count", 32'(underflow_count), 32'(m_cnt));
   end

   task automatic do_reset();
      @(negedge clock);
      reset_n         = 1'b0;
      in_valid        = 1'b0;
      underflow_clear = 1'b0;
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
   endtask

   // Called on a falling edge; returns on the falling edge after the accepting edge.
   task automatic send(input logic [W-1:0] w);
      int guard = 0;
      in_data  = w;
      in_valid = 1'b1;
      while (in_ready !== 1'b1 && guard < 50) begin
         @(negedge clock);
         guard++;
      end
      if (guard >= 50) chk("send_timeout", 32'd1, 32'd0);
      @(negedge clock);
      in_valid = 1'b0;
   endtask

   logic [W-1:0] words[10];
   logic [6:0]   exp_bits;
   int           guard;

   initial begin
      reset_n = 1'b0; in_valid = 1'b0; in_data = '0; underflow_clear = 1'b0;

      // Idle line after reset: two loads, both idle.
      do_reset();
      for (int i = 0; i < 14; i++) begin
         @(negedge clock);
         chk("idle_clk_pattern", 32'(serial_clock), 32'(c_pat[6 - (i % 7)]));
      end
      chk("idle_underflow", 32'(underflow), 32'd1);
      chk("idle_count", 32'(underflow_count), 32'd2);

      // Single word present at release goes straight out on the first load.
      do_reset();
      exp_bits = 7'b1010011;
      send(28'h0000053);
      for (int i = 0; i < 7; i++) begin
         chk("word_lane0_bit", 32'(serial_data[0]), 32'(exp_bits[6-i]));
         chk("word_slot0", 32'(frame_slot0), 32'(i == 0));
         if (i < 6) @(negedge clock);
      end
      chk("word_count", 32'(underflow_count), 32'd0);

      // Back-to-back stream of ten words.
      do_reset();
      for (int i = 0; i < 10; i++) words[i] = 28'(32'h0A5C3E1 * (i + 1));
      for (int i = 0; i < 10; i++) send(words[i]);
      chk("stream_underflow", 32'(underflow), 32'd0);
      chk("stream_count", 32'(underflow_count), 32'd0);
      repeat (8) @(negedge clock);
      chk("stream_len", 32'(tx_log.size() >= 10), 32'd1);
      for (int i = 0; i < 10 && i < tx_log.size(); i++) chk("stream_order", 32'(tx_log[i]), 32'(words[i]));

      // Gap of 30 clocks mid-stream: three missed loads, then D intact.
      do_reset();
      send(28'h1111111); send(28'h2222222); send(28'h3333333);
      repeat (30) @(negedge clock);
      send(28'h4444444);
      guard = 0;
      while (tx_log.size() < 7 && guard < 20) begin @(negedge clock); guard++; end
      chk("gap_len", 32'(tx_log.size()), 32'd7);
      chk("gap_count", 32'(underflow_count), 32'd3);
      if (tx_log.size() >= 7) begin
         chk("gap_idle", 32'(tx_log[4]), 32'(IDLE));
         chk("gap_resume", 32'(tx_log[6]), 32'h4444444);
      end

      // Clear on the same edge as an idle insertion, then saturation.
      do_reset();
      underflow_clear = 1'b1;
      @(negedge clock);
      underflow_clear = 1'b0;
      chk("clr_underflow", 32'(underflow), 32'd0);
      chk("clr_count", 32'(underflow_count), 32'd0);
      repeat (7) @(negedge clock);
      chk("clr_next_count", 32'(underflow_count), 32'd1);
      #2;
      force dut.underflow_count_q = 16'hFFFF;
      m_cnt = 16'hFFFF;
      @(negedge clock);
      release dut.underflow_count_q;
      repeat (6) @(negedge clock);
      chk("sat_count", 32'(underflow_count), 32'h0000FFFF);
      chk("sat_underflow", 32'(underflow), 32'd1);

      // Reset in slot 3 with a word waiting in the holding register.
      do_reset();
      send(28'h5A5A5A5);
      send(28'h7E7E7E7);
      @(negedge clock);
      chk("abort_hold_full", 32'(in_ready), 32'd0);
      @(posedge clock);
      #2 reset_n = 1'b0;
      in_valid = 1'b0;
      #1;
      chk("abort_serial_data", 32'(serial_data), 32'd0);
      chk("abort_serial_clock", 32'(serial_clock), 32'd0);
      chk("abort_frame_slot0", 32'(frame_slot0), 32'd0);
      chk("abort_in_ready", 32'(in_ready), 32'd1);
      @(negedge clock);
      reset_n = 1'b1;
      repeat (14) @(negedge clock);
      chk("abort_len", 32'(tx_log.size()), 32'd2);
      chk("abort_count", 32'(underflow_count), 32'd2);
      if (tx_log.size() >= 2) begin
         chk("abort_word0", 32'(tx_log[0]), 32'(IDLE));
         chk("abort_word1", 32'(tx_log[1]), 32'(IDLE));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, time %0t limit 500000", $time);
      $fatal(1);
   end

endmodule
`default_nettype wire

// File: doc/ldi_serializer.md
LDI_SERIALIZER -- requirements
Module: ldi_serializer

Interface
REQ-001 Parameter LANES, default 4: number of LVDS data lanes; legal range 1..8.
REQ-002 Parameter IDLE_WORD, default 0 (width 7*LANES): word sent when no pixel word is available.
REQ-003 clock  input  1  serial bit clock, 7x pixel rate; all logic on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 in_data  input  7*LANES  pixel word; lane k occupies bits [7k+6:7k], bit 7k+6 transmitted first.
REQ-006 in_valid  input  1  in_data valid.
REQ-007 in_ready  output  1  block can accept a word this cycle.
REQ-008 serial_data  output  LANES  serial lane outputs, one bit per clock.
REQ-009 serial_clock  output  1  LDI clock-lane pattern output.
REQ-010 frame_slot0  output  1  high during the clock in which bit slot 0 is driven.
REQ-011 underflow  output  1  sticky: an idle word was inserted since the last clear.
REQ-012 underflow_count  output  16  count of inserted idle words, saturating at 16'hFFFF.
REQ-013 underflow_clear  input  1  synchronous clear of underflow and underflow_count.

Function
REQ-014 Slot counter: 3 bits, counts 0,1,...,6,0; never holds 7.
REQ-015 One-entry holding register (hold_data, hold_full) between the input and the shift register.
REQ-016 in_ready SHALL equal !hold_full (registered state only, no combinational path from in_valid).
REQ-017 Accept: in_valid && in_ready at a rising edge.
REQ-018 Load event: the edge on which the slot counter goes 6 -> 0.
REQ-019 At load, if hold_full: shift register <= hold_data; hold_full <= 0.
REQ-020 At load, if !hold_full and an accept occurs on the same edge: in_data goes straight to the shift register; hold_full stays 0; no underflow.
REQ-021 At load, if !hold_full and no accept: shift register <= IDLE_WORD; underflow <= 1; underflow_count increments, saturating.
REQ-022 Accept on a non-load edge: hold_data <= in_data; hold_full <= 1.
REQ-023 Each lane shifts out MSB-first; serial_data[k] in slot s = word bit 7k+6-s.
REQ-024 serial_data, serial_clock and frame_slot0 SHALL be registered outputs, all aligned to the same slot.
REQ-025 serial_clock pattern for slots 0..6 = 1,1,0,0,0,1,1.
REQ-026 Latency: a word loaded at a load edge drives its slot-0 bits on the outputs for the following clock, i.e. the seven clocks after that edge.
REQ-027 underflow_clear has priority over a same-cycle underflow increment; the result is underflow=0, count=0.
REQ-028 Continuous in_valid=1 sustains one word per 7 clocks with no idle insertion.

Reset
REQ-029 While reset_n=0: serial_data=0, serial_clock=0, frame_slot0=0, hold_full=0, in_ready=1, underflow=0, underflow_count=0, slot counter=6, shift register=IDLE_WORD.
REQ-030 The first rising edge after release is a load event (REQ-019..021 apply).
REQ-031 Reset asserted mid-word aborts it immediately. A held word is discarded and not transmitted after release.

Verification
REQ-032 Reset release, in_valid=0 for 14 clocks, LANES=4 -> 2 idle words; serial_clock=1100011 repeating; underflow=1, count=2.
REQ-033 Word lane0=7'b1010011 presented with in_valid=1 from reset release, held until accepted -> accepted on the first load edge. serial_data[0] = 1,0,1,0,0,1,1 over the next 7 clocks, with frame_slot0 high on the first of them; count=0.
REQ-034 Back-to-back stream, in_valid=1 for 10 words with incrementing data -> every word transmitted in order, in_ready high once per 7 clocks, underflow stays 0.
REQ-035 in_valid=0 for 30 clocks mid-stream, then data resumes -> idle words inserted only at load edges, count equals the number of missed loads, and the first resumed word is intact.
REQ-036 underflow_clear pulsed on the same edge as an idle insertion -> underflow=0, count=0. Count forced to 16'hFFFF then another idle inserted -> stays 16'hFFFF.
REQ-037 reset_n pulsed low in slot 3 with hold_full=1 -> outputs 0 immediately, in_ready=1, and the held word never appears on the outputs.
